// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings, default iteration count and operand magnitude helper.
package muldiv_pkg;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: 64-bit accumulator doing one shift-add or restoring divide step per cycle,
// plus the sign-corrected HI/LO result.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic        is_div, sgn, ge;
  logic [31:0] a_mag, b_mag, quo, rem;
  logic [32:0] sum, rem_sh, diff;
  logic [63:0] acc_q, acc_d, step_val, prod;
  logic [31:0] b_q;
  logic        is_div_q, neg_q, rneg_q, dz_q;

  always_comb begin
    is_div   = (op_i == OP_DIV) || (op_i == OP_DIVU);
    sgn      = (op_i == OP_DIV) || (op_i == OP_MULT);
    a_mag    = abs32(rs_i, sgn);
    b_mag    = abs32(rt_i, sgn);
    sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem_sh   = {acc_q[63:32], acc_q[31]};
    diff     = rem_sh - {1'b0, b_q};
    // partial remainder stays below the divisor, so a borrow in bit 32 means "doesn't fit"
    ge       = ~diff[32];
    step_val = is_div_q ? (ge ? {diff[31:0], acc_q[30:0], 1'b1} : {rem_sh[31:0], acc_q[30:0], 1'b0})
                        : {sum, acc_q[31:1]};
    acc_d    = load_i ? {32'd0, is_div ? a_mag : b_mag} : step_i ? step_val : acc_q;
    prod     = neg_q ? -acc_q : acc_q;
    quo      = dz_q ? 32'hFFFF_FFFF : neg_q ? -acc_q[31:0] : acc_q[31:0];
    rem      = rneg_q ? -acc_q[63:32] : acc_q[63:32];
    res_hi_o = is_div_q ? rem : prod[63:32];
    res_lo_o = is_div_q ? quo : prod[31:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (load_i) begin
        b_q      <= is_div ? b_mag : a_mag;
        is_div_q <= is_div;
        neg_q    <= sgn & (rs_i[31] ^ rt_i[31]);
        rneg_q   <= sgn & is_div & rs_i[31];
        dz_q     <= is_div & (rt_i == 32'd0);
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: IDLE/RUN/FIX control, iteration counter, HI/LO registers and pipeline stall.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        mfhi_req,
  input  logic        mflo_req,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int CW = $clog2(ITER + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
  logic            done_q, done_d, load, step;

  muldiv_datapath u_dp (
    .clk     (clk),
    .rst     (reset),
    .load_i  (load),
    .step_i  (step),
    .op_i    (op),
    .rs_i    (rs_val),
    .rt_i    (rt_val),
    .res_hi_o(res_hi),
    .res_lo_o(res_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // start wins over a same-cycle mthi/mtlo
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          load    = 1'b1;
        end else begin
          hi_d = mthi ? rs_val : hi_q;
          lo_d = mtlo ? rs_val : lo_q;
        end
      end
      S_RUN: begin
        step    = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(ITER - 1)) ? S_FIX : S_RUN;
      end
      S_FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | mfhi_req | mflo_req | mthi | mtlo);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of latency, arithmetic corner cases, stall, mthi/mtlo and reset abort.
module tb_muldiv_sequencer;

  logic        clk, reset, start, mthi, mtlo, mfhi_req, mflo_req;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;
  logic        busy, done, stall;
  int          errors = 0;
  int          checks = 0;
  logic        saw_done;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .mfhi_req(mfhi_req), .mflo_req(mflo_req),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // start in cycle 0, expect busy through cycle 33 and the result with done in cycle 34
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick;
    start = 1'b0;
    chk1({tag, "_busy1"}, busy, 1'b1);
    repeat (32) tick;
    chk1({tag, "_busy33"}, busy, 1'b1);
    chk1({tag, "_done33"}, done, 1'b0);
    tick;
    chk32({tag, "_hi"}, hi, eh);
    chk32({tag, "_lo"}, lo, el);
    chk1({tag, "_done34"}, done, 1'b1);
    chk1({tag, "_busy34"}, busy, 1'b0);
    tick;
    chk1({tag, "_done35"}, done, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; mfhi_req = 1'b0; mflo_req = 1'b0;
    op = 2'b00; rs_val = '0; rt_val = '0;
    tick; tick;
    reset = 1'b0;
    chk32("rst_hi", hi, 32'h0);
    chk32("rst_lo", lo, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_stall", stall, 1'b0);

    mthi = 1'b1; rs_val = 32'h1234_5678;
    tick;
    mthi = 1'b0;
    chk32("mthi_idle", hi, 32'h1234_5678);
    mtlo = 1'b1; rs_val = 32'h9ABC_DEF0;
    tick;
    mtlo = 1'b0;
    chk32("mtlo_idle", lo, 32'h9ABC_DEF0);
    chk32("mtlo_hi_kept", hi, 32'h1234_5678);
    mflo_req = 1'b1;
    #1;
    chk1("stall_idle", stall, 1'b0);
    mflo_req = 1'b0;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_big", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_zero", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // mflo_req raised in cycle 5 of a MULTU 6*7
    op = 2'b01; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) mflo_req = 1'b1;
      #1;
      chk1($sformatf("mflo_stall_c%0d", c), stall, c >= 5);
      tick;
    end
    #1;
    chk1("mflo_stall_c34", stall, 1'b0);
    chk32("mflo_lo_c34", lo, 32'd42);
    chk1("mflo_done_c34", done, 1'b1);
    mflo_req = 1'b0;

    // mthi and a second start while busy are ignored
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    mthi = 1'b1; rs_val = 32'hDEAD_BEEF;
    #1;
    chk1("busy_mthi_stall", stall, 1'b1);
    tick;
    mthi = 1'b0;
    chk32("busy_mthi_hi", hi, 32'h0);
    op = 2'b01; rs_val = 32'd5; rt_val = 32'd5; start = 1'b1;
    #1;
    chk1("busy_start_stall", stall, 1'b1);
    tick;
    start = 1'b0;
    repeat (30) tick;
    chk32("busy_ign_hi", hi, 32'd2);
    chk32("busy_ign_lo", lo, 32'd14);
    chk1("busy_ign_done", done, 1'b1);
    tick;

    // reset in cycle 10 of a DIV aborts it
    op = 2'b10; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk32("abort_hi", hi, 32'h0);
    chk32("abort_lo", lo, 32'h0);
    chk1("abort_done", done, 1'b0);
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      saw_done = saw_done | done;
      tick;
    end
    chk1("abort_no_done", saw_done, 1'b0);
    run_op("div_after_abort", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    // start wins over a same-cycle mthi
    op = 2'b01; rs_val = 32'd2; rt_val = 32'd3; start = 1'b1; mthi = 1'b1;
    tick;
    start = 1'b0; mthi = 1'b0;
    chk32("start_mthi_hi1", hi, 32'hFFFF_FFFE);
    chk1("start_mthi_busy", busy, 1'b1);
    repeat (33) tick;
    chk32("start_mthi_hi", hi, 32'h0);
    chk32("start_mthi_lo", lo, 32'd6);
    chk1("start_mthi_done", done, 1'b1);
    tick;

    // reset wins over mthi/mtlo
    reset = 1'b1; mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hAAAA_5555;
    tick;
    reset = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk32("rst_mthi_hi", hi, 32'h0);
    chk32("rst_mtlo_lo", lo, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
